// File: rtl/clock_set_ctrl.sv
// Button front end for the millennium clock: field select FSM, inc/dec pulses with
// hold-to-repeat, idle timeout back to RUN. Optional blink strobe: CLOCK_SET_BLINK_EN.
module clock_set_ctrl #(
   parameter int unsigned HOLD_CYC    = 25_000_000,
   parameter int unsigned REPEAT_CYC  = 5_000_000,
   parameter int unsigned TIMEOUT_CYC = 500_000_000,
   parameter int unsigned BLINK_CYC   = 12_500_000
) (
   input  logic clk_50MHz,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_up,
   input  logic btn_down,
   output logic set_sec,
   output logic set_min,
   output logic set_hour,
   output logic set_day,
   output logic set_month,
   output logic set_year,
   output logic inc,
   output logic dec,
   output logic editing,
   output logic blink
);

   localparam int unsigned HW = $clog2(HOLD_CYC) + 1;
   localparam int unsigned RW = $clog2(REPEAT_CYC) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

   if (HOLD_CYC < 2 || REPEAT_CYC < 1 || TIMEOUT_CYC < 2 || BLINK_CYC < 1) begin : g_bad_param
      $error("clock_set_ctrl: cycle parameters out of range");
   end

   typedef enum logic [2:0] {RUN, SEC, MIN, HOUR, DAY, MONTH, YEAR} state_t;
   typedef enum logic [1:0] {ACT_NONE, ACT_UP, ACT_DOWN} act_t;

   state_t        state_q, state_d;
   act_t          act_q, act_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [RW-1:0] rep_q, rep_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          mode_q, up_q, down_q;
   logic          press_mode, press_up, press_down, any_btn, rpt;
   logic          inc_q, inc_d, dec_q, dec_d, editing_q;
   logic [5:0]    set_q, set_d;

   always_comb begin
      press_mode = btn_mode & ~mode_q;
      press_up   = btn_up & ~up_q;
      press_down = btn_down & ~down_q;
      any_btn    = btn_mode | btn_up | btn_down;
      state_d    = state_q;
      act_d      = act_q;
      hold_d     = hold_q;
      rep_d      = rep_q;
      idle_d     = idle_q;
      inc_d      = 1'b0;
      dec_d      = 1'b0;
      rpt        = 1'b0;
      if (state_q == RUN) begin
         act_d  = ACT_NONE;
         hold_d = '0;
         rep_d  = '0;
         idle_d = '0;
         if (press_mode) state_d = SEC;
      end else begin
         if (any_btn || idle_q == TW'(TIMEOUT_CYC - 1)) idle_d = '0;
         else idle_d = idle_q + TW'(1);
         // Priority: mode edge, timeout, up+down conflict, fresh press, continued hold.
         if (press_mode) begin
            act_d  = ACT_NONE;
            hold_d = '0;
            rep_d  = '0;
            case (state_q)
               SEC:     state_d = MIN;
               MIN:     state_d = HOUR;
               HOUR:    state_d = DAY;
               DAY:     state_d = MONTH;
               MONTH:   state_d = YEAR;
               default: state_d = RUN;
            endcase
         end else if (!any_btn && idle_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = RUN;
            act_d   = ACT_NONE;
            hold_d  = '0;
            rep_d   = '0;
         end else if (btn_up && btn_down) begin
            act_d  = ACT_NONE;
            hold_d = '0;
            rep_d  = '0;
         end else if (press_up || press_down) begin
            act_d  = press_up ? ACT_UP : ACT_DOWN;
            hold_d = HW'(1);
            rep_d  = '0;
            inc_d  = press_up;
            dec_d  = press_down;
         end else if ((act_q == ACT_UP && btn_up) || (act_q == ACT_DOWN && btn_down)) begin
            if (hold_q != HW'(HOLD_CYC)) begin
               hold_d = hold_q + HW'(1);
               rpt    = (hold_d == HW'(HOLD_CYC));
            end else begin
               rep_d = rep_q + RW'(1);
               if (rep_d == RW'(REPEAT_CYC)) begin
                  rpt   = 1'b1;
                  rep_d = '0;
               end
            end
            inc_d = rpt & (act_q == ACT_UP);
            dec_d = rpt & (act_q == ACT_DOWN);
         end else begin
            act_d  = ACT_NONE;
            hold_d = '0;
            rep_d  = '0;
         end
      end
   end

   always_comb begin
      set_d = '0;
      case (state_d)
         SEC:     set_d = 6'b000001;
         MIN:     set_d = 6'b000010;
         HOUR:    set_d = 6'b000100;
         DAY:     set_d = 6'b001000;
         MONTH:   set_d = 6'b010000;
         YEAR:    set_d = 6'b100000;
         default: set_d = '0;
      endcase
   end

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state_q   <= RUN;
         act_q     <= ACT_NONE;
         hold_q    <= '0;
         rep_q     <= '0;
         idle_q    <= '0;
         mode_q    <= 1'b0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         editing_q <= 1'b0;
         set_q     <= '0;
      end else begin
         state_q   <= state_d;
         act_q     <= act_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         idle_q    <= idle_d;
         mode_q    <= btn_mode;
         up_q      <= btn_up;
         down_q    <= btn_down;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         editing_q <= (state_d != RUN);
         set_q     <= set_d;
      end
   end

`ifdef CLOCK_SET_BLINK_EN
   localparam int unsigned BW = $clog2(BLINK_CYC) + 1;

   logic [BW-1:0] bcnt_q, bforce_q;
   logic          blink_q;

   // Any inc/dec pins the field visible for BLINK_CYC cycles before blinking resumes.
   always_ff @(posedge clk_50MHz) begin
      if (rst || state_d == RUN) begin
         bcnt_q   <= '0;
         bforce_q <= '0;
         blink_q  <= 1'b0;
      end else if (state_d != state_q) begin
         bcnt_q   <= '0;
         bforce_q <= '0;
         blink_q  <= 1'b1;
      end else if (inc_d || dec_d) begin
         bcnt_q   <= '0;
         bforce_q <= BW'(BLINK_CYC);
         blink_q  <= 1'b1;
      end else if (bforce_q != '0) begin
         bforce_q <= bforce_q - BW'(1);
         blink_q  <= 1'b1;
      end else if (bcnt_q == BW'(BLINK_CYC - 1)) begin
         bcnt_q  <= '0;
         blink_q <= ~blink_q;
      end else begin
         bcnt_q <= bcnt_q + BW'(1);
      end
   end

   assign blink = blink_q;
`else
   assign blink = editing_q;
`endif

   assign {set_year, set_month, set_day, set_hour, set_min, set_sec} = set_q;
   assign inc     = inc_q;
   assign dec     = dec_q;
   assign editing = editing_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short timing parameters.
module tb_clock_set_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic set_sec, set_min, set_hour, set_day, set_month, set_year;
   logic inc, dec, editing, blink;
   logic [5:0] sets;
   int checks = 0;
   int errors = 0;
   int pulses;

   assign sets = {set_year, set_month, set_day, set_hour, set_min, set_sec};

   always #5 clk = ~clk;

   clock_set_ctrl #(
      .HOLD_CYC(8),
      .REPEAT_CYC(4),
      .TIMEOUT_CYC(64),
      .BLINK_CYC(6)
   ) dut (
      .clk_50MHz(clk),
      .rst(rst),
      .btn_mode(btn_mode),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .set_sec(set_sec),
      .set_min(set_min),
      .set_hour(set_hour),
      .set_day(set_day),
      .set_month(set_month),
      .set_year(set_year),
      .inc(inc),
      .dec(dec),
      .editing(editing),
      .blink(blink)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones(sets) <= 1), 32'd1);
      chk("incdec_excl", 32'(inc & dec), 32'd0);
   endtask

   task automatic chk_sel(input string tag, input logic [5:0] exp_sets);
      chk({tag, "_sets"}, 32'(sets), 32'(exp_sets));
      chk({tag, "_editing"}, 32'(editing), 32'(exp_sets != 6'd0));
`ifndef CLOCK_SET_BLINK_EN
      chk({tag, "_blink"}, 32'(blink), 32'(exp_sets != 6'd0));
`endif
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      tick();
      tick();
      btn_mode = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sets"}, 32'(sets), 32'd0);
      chk({tag, "_editing"}, 32'(editing), 32'd0);
      chk({tag, "_inc"}, 32'(inc), 32'd0);
      chk({tag, "_dec"}, 32'(dec), 32'd0);
      chk({tag, "_blink"}, 32'(blink), 32'd0);
   endtask

   initial begin
      logic [5:0] exp_sets;
      logic       exp_p;

      rst = 1'b1;
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;

      for (int i = 1; i <= 7; i++) begin
         press_mode();
         repeat (3) tick();
         exp_sets = (i < 7) ? 6'(1 << (i - 1)) : 6'd0;
         chk_sel("mode_cycle", exp_sets);
      end

      btn_up = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("run_ignore_inc", 32'(inc), 32'd0);
         chk("run_ignore_editing", 32'(editing), 32'd0);
      end
      btn_up = 1'b0;
      tick();

      press_mode();
      tick();
      chk_sel("enter_sec", 6'b000001);
      btn_up = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("single_inc", 32'(inc), 32'(k == 0));
         chk("single_dec", 32'(dec), 32'd0);
      end
      btn_up = 1'b0;
      repeat (3) begin
         tick();
         chk("single_after_inc", 32'(inc), 32'd0);
      end

      press_mode();
      tick();
      chk_sel("enter_min", 6'b000010);
      pulses = 0;
      btn_down = 1'b1;
      for (int k = 0; k < 22; k++) begin
         tick();
         exp_p = (k + 1 == 1) || (k + 1 == 8) || (k + 1 == 12) || (k + 1 == 16) || (k + 1 == 20);
         chk("repeat_dec", 32'(dec), 32'(exp_p));
         chk("repeat_inc", 32'(inc), 32'd0);
         pulses += int'(dec);
      end
      chk("repeat_count", 32'(pulses), 32'd5);
      btn_down = 1'b0;
      repeat (10) begin
         tick();
         chk("release_dec", 32'(dec), 32'd0);
      end

      press_mode();
      tick();
      chk_sel("enter_hour", 6'b000100);
      btn_up = 1'b1;
      btn_down = 1'b1;
      repeat (20) begin
         tick();
         chk("conflict_inc", 32'(inc), 32'd0);
         chk("conflict_dec", 32'(dec), 32'd0);
      end
      btn_up = 1'b0;
      btn_down = 1'b0;
      tick();

      press_mode();
      repeat (63) tick();
      chk_sel("timeout_before", 6'b001000);
      tick();
      chk_sel("timeout_after", 6'b000000);

      press_mode();
      tick();
      chk_sel("prio_sec", 6'b000001);
      btn_mode = 1'b1;
      btn_up = 1'b1;
      tick();
      chk_sel("prio_adv", 6'b000010);
      chk("prio_inc", 32'(inc), 32'd0);
      tick();
      chk_sel("prio_held", 6'b000010);
      chk("prio_held_inc", 32'(inc), 32'd0);
      btn_mode = 1'b0;
      btn_up = 1'b0;
      tick();

      repeat (4) begin
         press_mode();
         tick();
      end
      chk_sel("enter_year", 6'b100000);
      btn_up = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         chk("year_inc", 32'(inc), 32'((k + 1 == 1) || (k + 1 == 8)));
      end
      rst = 1'b1;
      tick();
      chk_zero("mid_reset");
      rst = 1'b0;
      repeat (10) begin
         tick();
         chk("post_reset_inc", 32'(inc), 32'd0);
         chk("post_reset_editing", 32'(editing), 32'd0);
      end
      btn_up = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
